// File: rtl/nvme_wr_completion_ctrl_pkg.sv
// nvme_wr_completion_ctrl_pkg: shared types, defaults and doorbell address helper
package nvme_wr_completion_ctrl_pkg;
  localparam int OUTSTANDING_DEF = 16;
  localparam int CQ_DEPTH_DEF = 16;
  localparam logic [31:0] DB_BASE_DEF = 32'h1000;
  typedef enum logic [1:0] {OKAY = 2'd0, EXOKAY = 2'd1, SLVERR = 2'd2, DECERR = 2'd3} axi_resp_e;
  typedef enum logic [1:0] {IDLE, SQDB, CQDB, WAIT_B} db_state_e;
  typedef struct packed {
    logic [15:0] cid;
    logic [15:0] sqhd;
    logic [14:0] status;
  } cqe_t;
  // SQ tail doorbell at index 2*qid, CQ head doorbell at 2*qid+1
  function automatic logic [31:0] db_addr(logic [31:0] base, int qid, int dstrd, logic is_cq);
    return base + 32'((2 * qid + int'(is_cq)) * (4 << dstrd));
  endfunction
endpackage

// File: rtl/nvme_wr_completion_ctrl_if.sv
// nvme_wr_completion_ctrl_if: AXI-Lite write master bus used for doorbell writes
interface nvme_wr_completion_ctrl_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic        arvalid;
  logic        rready;
  modport master(output awaddr, awvalid, wdata, wstrb, wvalid, bready, arvalid, rready,
                 input awready, wready, bresp, bvalid);
  modport slave(input awaddr, awvalid, wdata, wstrb, wvalid, bready, arvalid, rready,
                output awready, wready, bresp, bvalid);
endinterface

// File: rtl/nvme_wr_completion_ctrl_db_writer.sv
// nvme_wr_completion_ctrl_db_writer: single-outstanding AXI-Lite write engine
module nvme_wr_completion_ctrl_db_writer
  import nvme_wr_completion_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  output logic        sent,
  output logic        done,
  output logic        err,
  nvme_wr_completion_ctrl_if.master nl
);
  logic awv, wv, busy;
  logic [31:0] awaddr_q, wdata_q;
  assign nl.awvalid = awv;
  assign nl.wvalid = wv;
  assign nl.awaddr = awaddr_q;
  assign nl.wdata = wdata_q;
  assign nl.wstrb = 4'hF;
  assign nl.bready = rstn;
  assign nl.arvalid = 1'b0;
  assign nl.rready = rstn;
  assign done = busy & nl.bvalid & nl.bready;
  assign err = done & (nl.bresp != OKAY);
  assign sent = busy & ~awv & ~wv;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      awv <= 1'b0;
      wv <= 1'b0;
      busy <= 1'b0;
      awaddr_q <= '0;
      wdata_q <= '0;
    end else if (req) begin
      awv <= 1'b1;
      wv <= 1'b1;
      busy <= 1'b1;
      awaddr_q <= addr;
      wdata_q <= data;
    end else begin
      awv <= awv & ~nl.awready;
      wv <= wv & ~nl.wready;
      busy <= busy & ~done;
    end
  end
endmodule

// File: rtl/nvme_wr_completion_ctrl.sv
// nvme_wr_completion_ctrl: in-order host B responses from SQ/WB responses, SQ tail / CQ head doorbells
module nvme_wr_completion_ctrl
  import nvme_wr_completion_ctrl_pkg::*;
#(
  parameter int          OUTSTANDING = OUTSTANDING_DEF,
  parameter int          CQ_DEPTH = CQ_DEPTH_DEF,
  parameter int          QID = 1,
  parameter int          DSTRD = 0,
  parameter logic [31:0] DB_BASE = DB_BASE_DEF,
  localparam int         SLOT_W = $clog2(OUTSTANDING)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              issue_valid,
  input  logic              sq_bvalid,
  input  logic [1:0]        sq_bresp,
  output logic              sq_bready,
  input  logic              wb_bvalid,
  input  logic [1:0]        wb_bresp,
  output logic              wb_bready,
  output logic              hp_bvalid,
  output logic [1:0]        hp_bresp,
  input  logic              hp_bready,
  nvme_wr_completion_ctrl_if.master nl,
  input  logic              cqe_valid,
  input  logic [15:0]       cqe_cid,
  input  logic [15:0]       cqe_sqhd,
  input  logic [14:0]       cqe_status,
  output logic              cqe_ready,
  output logic [SLOT_W-1:0] cqdb_sqhead,
  output logic              err_sticky,
  output logic [15:0]       err_cid
);
  localparam int CQ_W = $clog2(CQ_DEPTH);
  localparam logic [OUTSTANDING-1:0] ONE = OUTSTANDING'(1);
  localparam logic [31:0] SQ_DB = db_addr(DB_BASE, QID, DSTRD, 1'b0);
  localparam logic [31:0] CQ_DB = db_addr(DB_BASE, QID, DSTRD, 1'b1);
  logic [SLOT_W-1:0] issue_ptr, sqb_ptr, wbb_ptr, stage_ptr, hpb_ptr, db_tail;
  logic [OUTSTANDING-1:0] sq_done, wb_done, slot_err, stage_clr, hp_clr, sq_set, wb_set, err_set;
  logic [CQ_W-1:0] cq_head, cq_db_head;
  logic sq_hs, wb_hs, hp_hs, cqe_hs, stage, sq_pend, cq_pend, cid_seen, last_sq;
  logic wr_req, wr_sent, wr_done, wr_err, unused;
  logic [31:0] wr_addr, wr_data;
  db_state_e state;
  cqe_t cqe;
  assign cqe = '{cid: cqe_cid, sqhd: cqe_sqhd, status: cqe_status};
  assign sq_bready = rstn;
  assign wb_bready = rstn;
  assign cqe_ready = rstn;
  assign sq_hs = sq_bvalid & sq_bready;
  assign wb_hs = wb_bvalid & wb_bready;
  assign cqe_hs = cqe_valid & cqe_ready;
  assign stage = sq_done[stage_ptr] & wb_done[stage_ptr];
  assign hp_bvalid = hpb_ptr != stage_ptr;
  assign hp_bresp = slot_err[hpb_ptr] ? SLVERR : OKAY;
  assign hp_hs = hp_bvalid & hp_bready;
  assign stage_clr = stage ? ONE << stage_ptr : '0;
  assign hp_clr = hp_hs ? ONE << hpb_ptr : '0;
  assign sq_set = sq_hs ? ONE << sqb_ptr : '0;
  assign wb_set = wb_hs ? ONE << wbb_ptr : '0;
  assign err_set = ((sq_hs && sq_bresp != OKAY) ? ONE << sqb_ptr : '0) |
                   ((wb_hs && wb_bresp != OKAY) ? ONE << wbb_ptr : '0);
  assign sq_pend = db_tail != stage_ptr;
  assign cq_pend = cq_head != cq_db_head;
  assign unused = &{1'b0, cqe.sqhd[15:SLOT_W], issue_ptr};
  // Staging reads the done bits registered last cycle, so a B response is staged one cycle later
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      issue_ptr <= '0;
      sqb_ptr <= '0;
      wbb_ptr <= '0;
      stage_ptr <= '0;
      hpb_ptr <= '0;
      sq_done <= '0;
      wb_done <= '0;
      slot_err <= '0;
    end else begin
      issue_ptr <= issue_ptr + SLOT_W'(issue_valid);
      sqb_ptr <= sqb_ptr + SLOT_W'(sq_hs);
      wbb_ptr <= wbb_ptr + SLOT_W'(wb_hs);
      stage_ptr <= stage_ptr + SLOT_W'(stage);
      hpb_ptr <= hpb_ptr + SLOT_W'(hp_hs);
      sq_done <= (sq_done & ~stage_clr) | sq_set;
      wb_done <= (wb_done & ~stage_clr) | wb_set;
      slot_err <= (slot_err & ~hp_clr) | err_set;
    end
  end
  // SQ tail has priority unless the previous doorbell was also a tail write and a head is pending
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      db_tail <= '0;
      cq_db_head <= '0;
      last_sq <= 1'b0;
      wr_req <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_req <= 1'b0;
      case (state)
        IDLE:
          if (sq_pend && !(cq_pend && last_sq)) begin
            state <= SQDB;
            db_tail <= stage_ptr;
            wr_req <= 1'b1;
            wr_addr <= SQ_DB;
            wr_data <= 32'(stage_ptr);
            last_sq <= 1'b1;
          end else if (cq_pend) begin
            state <= CQDB;
            cq_db_head <= cq_head;
            wr_req <= 1'b1;
            wr_addr <= CQ_DB;
            wr_data <= 32'(cq_head);
            last_sq <= 1'b0;
          end
        SQDB, CQDB: state <= wr_done ? IDLE : wr_sent ? WAIT_B : state;
        default: state <= wr_done ? IDLE : state;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cq_head <= '0;
      cqdb_sqhead <= '0;
      err_sticky <= 1'b0;
      err_cid <= '0;
      cid_seen <= 1'b0;
    end else begin
      if (cqe_hs) begin
        cq_head <= cq_head + CQ_W'(1);
        cqdb_sqhead <= cqe.sqhd[SLOT_W-1:0];
      end
      if (cqe_hs && cqe.status != '0 && !cid_seen) begin
        err_cid <= cqe.cid;
        cid_seen <= 1'b1;
      end
      if ((cqe_hs && cqe.status != '0) || err_set != '0 || wr_err) err_sticky <= 1'b1;
    end
  end
  nvme_wr_completion_ctrl_db_writer u_wr (
    .clk  (clk),
    .rstn (rstn),
    .req  (wr_req),
    .addr (wr_addr),
    .data (wr_data),
    .sent (wr_sent),
    .done (wr_done),
    .err  (wr_err),
    .nl   (nl)
  );
endmodule

// File: tb/tb_nvme_wr_completion_ctrl.sv
// tb_nvme_wr_completion_ctrl: directed stimulus, queue scoreboard on host B, AXI-Lite doorbell responder
module tb_nvme_wr_completion_ctrl;
  logic clk = 1'b0;
  logic rstn, issue_valid, sq_bvalid, wb_bvalid, hp_bready, cqe_valid;
  logic [1:0] sq_bresp, wb_bresp;
  logic sq_bready, wb_bready, hp_bvalid, cqe_ready, err_sticky;
  logic [1:0] hp_bresp;
  logic [15:0] cqe_cid, cqe_sqhd, err_cid;
  logic [14:0] cqe_status;
  logic [3:0] cqdb_sqhead;
  int n_cmp = 0, n_err = 0;
  logic [1:0] exp_q[$];
  int sq_cnt = 0, cq_cnt = 0;
  logic [31:0] sq_last = 0, cq_last = 0;
  logic sq_wrapped = 0, cq_wrapped = 0, aw_stall = 0;

  nvme_wr_completion_ctrl_if nl();

  nvme_wr_completion_ctrl dut (
    .clk(clk), .rstn(rstn), .issue_valid(issue_valid),
    .sq_bvalid(sq_bvalid), .sq_bresp(sq_bresp), .sq_bready(sq_bready),
    .wb_bvalid(wb_bvalid), .wb_bresp(wb_bresp), .wb_bready(wb_bready),
    .hp_bvalid(hp_bvalid), .hp_bresp(hp_bresp), .hp_bready(hp_bready),
    .nl(nl.master),
    .cqe_valid(cqe_valid), .cqe_cid(cqe_cid), .cqe_sqhd(cqe_sqhd), .cqe_status(cqe_status),
    .cqe_ready(cqe_ready), .cqdb_sqhead(cqdb_sqhead), .err_sticky(err_sticky), .err_cid(err_cid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input int n);
    repeat (n) tick();
  endtask

  task automatic cqe(input logic [15:0] cid, input logic [15:0] sqhd, input logic [14:0] st);
    cqe_valid = 1'b1;
    cqe_cid = cid;
    cqe_sqhd = sqhd;
    cqe_status = st;
    tick();
    cqe_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // host B monitor: pops the scoreboard on each handshake, checks hold/stability under backpressure
  initial begin
    logic pv, pr;
    logic [1:0] presp;
    pv = 1'b0;
    pr = 1'b0;
    presp = 2'd0;
    forever begin
      @(negedge clk);
      if (!rstn) pv = 1'b0;
      else begin
        if (pv && !pr) begin
          chk("hp_held", hp_bvalid, 1);
          if (hp_bvalid) chk("hp_stable", hp_bresp, presp);
        end
        if (hp_bvalid && hp_bready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL hp_extra: got resp %0d with nothing expected at %0t", hp_bresp, $time);
          end else chk("hp_bresp", hp_bresp, exp_q.pop_front());
        end
        pv = hp_bvalid;
        pr = hp_bready;
        presp = hp_bresp;
      end
    end
  end

  // AXI-Lite doorbell slave: records each completed write, answers OKAY one cycle later
  initial begin
    logic aw_hs, w_hs, b_hs, got_aw, got_w;
    logic [31:0] a, d;
    logic [3:0] s;
    got_aw = 1'b0;
    got_w = 1'b0;
    a = 0;
    d = 0;
    s = 0;
    nl.awready = 1'b1;
    nl.wready = 1'b1;
    nl.bvalid = 1'b0;
    nl.bresp = 2'd0;
    forever begin
      @(negedge clk);
      aw_hs = nl.awvalid && nl.awready;
      w_hs = nl.wvalid && nl.wready;
      b_hs = nl.bvalid && nl.bready;
      if (aw_hs) a = nl.awaddr;
      if (w_hs) begin
        d = nl.wdata;
        s = nl.wstrb;
      end
      @(posedge clk);
      #1;
      if (!rstn) begin
        got_aw = 1'b0;
        got_w = 1'b0;
        nl.bvalid = 1'b0;
      end else begin
        if (b_hs) nl.bvalid = 1'b0;
        got_aw = got_aw | aw_hs;
        got_w = got_w | w_hs;
        if (got_aw && got_w) begin
          chk("nl_addr_legal", (a == 32'h1008 || a == 32'h100C), 1);
          chk("nl_wstrb", s, 4'hF);
          chk("nl_data_range", d < 16, 1);
          if (a == 32'h1008) begin
            if (d < sq_last) sq_wrapped = 1'b1;
            sq_last = d;
            sq_cnt++;
          end else if (a == 32'h100C) begin
            if (d < cq_last) cq_wrapped = 1'b1;
            cq_last = d;
            cq_cnt++;
          end
          got_aw = 1'b0;
          got_w = 1'b0;
          nl.bvalid = 1'b1;
          nl.bresp = 2'd0;
        end
      end
      nl.awready = !aw_stall;
      nl.wready = !aw_stall;
    end
  end

  initial begin
    int base, k;
    rstn = 1'b0;
    issue_valid = 0; sq_bvalid = 0; wb_bvalid = 0; hp_bready = 1; cqe_valid = 0;
    sq_bresp = 0; wb_bresp = 0; cqe_cid = 0; cqe_sqhd = 0; cqe_status = 0;
    cyc(3);
    @(negedge clk);
    chk("rst_hp_bvalid", hp_bvalid, 0);
    chk("rst_awvalid", nl.awvalid, 0);
    chk("rst_wvalid", nl.wvalid, 0);
    chk("rst_sqhead", cqdb_sqhead, 0);
    chk("rst_err_sticky", err_sticky, 0);
    chk("rst_err_cid", err_cid, 0);
    chk("rst_sq_bready", sq_bready, 0);
    chk("rst_cqe_ready", cqe_ready, 0);
    chk("rst_nl_bready", nl.bready, 0);
    tick();
    rstn = 1'b1;
    @(negedge clk);
    chk("run_sq_bready", sq_bready, 1);
    chk("run_wb_bready", wb_bready, 1);
    chk("run_cqe_ready", cqe_ready, 1);
    chk("run_nl_bready", nl.bready, 1);
    chk("run_arvalid", nl.arvalid, 0);
    chk("run_rready", nl.rready, 1);

    // 1: single write, wb_b three cycles after sq_b
    tick();
    issue_valid = 1; exp_q.push_back(2'd0);
    tick();
    issue_valid = 0; sq_bvalid = 1;
    tick();
    sq_bvalid = 0;
    cyc(2);
    wb_bvalid = 1;
    tick();
    wb_bvalid = 0;
    @(negedge clk);
    chk("t1_hp_not_yet", hp_bvalid, 0);
    tick();
    @(negedge clk);
    chk("t1_hp_valid", hp_bvalid, 1);
    cyc(20);
    chk("t1_sq_writes", sq_cnt, 1);
    chk("t1_sq_data", sq_last, 1);

    // 2: wb responses all before sq responses
    base = sq_cnt;
    for (int i = 0; i < 4; i++) begin
      issue_valid = 1; exp_q.push_back(2'd0); tick();
    end
    issue_valid = 0;
    for (int i = 0; i < 4; i++) begin
      wb_bvalid = 1; tick();
    end
    wb_bvalid = 0;
    cyc(5);
    @(negedge clk);
    chk("t2_hold_no_sq", hp_bvalid, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      sq_bvalid = 1; tick();
    end
    sq_bvalid = 0;
    cyc(25);
    chk("t2_sq_data", sq_last, 5);
    chk("t2_sq_writes_1_or_2", (sq_cnt - base >= 1) && (sq_cnt - base <= 2), 1);
    chk("t2_q_empty", exp_q.size(), 0);

    // 3: host backpressure with three staged
    hp_bready = 0;
    for (int i = 0; i < 3; i++) begin
      issue_valid = 1; exp_q.push_back(2'd0); tick();
    end
    issue_valid = 0;
    for (int i = 0; i < 3; i++) begin
      sq_bvalid = 1; wb_bvalid = 1; tick();
    end
    sq_bvalid = 0; wb_bvalid = 0;
    cyc(20);
    @(negedge clk);
    chk("t3_hp_held", hp_bvalid, 1);
    chk("t3_none_taken", exp_q.size(), 3);
    tick();
    hp_bready = 1;
    cyc(8);
    chk("t3_q_empty", exp_q.size(), 0);

    // 5: error reporting (slots 8..11, third one fails on wb_b; then CQE statuses)
    for (int i = 0; i < 4; i++) begin
      issue_valid = 1; exp_q.push_back(i == 2 ? 2'd2 : 2'd0); tick();
    end
    issue_valid = 0;
    for (int i = 0; i < 4; i++) begin
      sq_bvalid = 1; wb_bvalid = 1; wb_bresp = (i == 2) ? 2'd2 : 2'd0; tick();
    end
    sq_bvalid = 0; wb_bvalid = 0; wb_bresp = 0;
    cyc(10);
    @(negedge clk);
    chk("t5_err_sticky", err_sticky, 1);
    chk("t5_err_cid_none", err_cid, 0);
    chk("t5_q_empty", exp_q.size(), 0);
    cqe(16'd5, 16'd12, 15'd0);
    @(negedge clk);
    chk("t5_cid_ok_cqe", err_cid, 0);
    chk("t5_sqhead", cqdb_sqhead, 12);
    cqe(16'd7, 16'd12, 15'h0281);
    @(negedge clk);
    chk("t5_cid_first", err_cid, 7);
    cqe(16'd9, 16'd13, 15'd1);
    @(negedge clk);
    chk("t5_cid_kept", err_cid, 7);
    chk("t5_sqhead2", cqdb_sqhead, 13);
    cyc(20);
    chk("t5_cq_data", cq_last, 3);

    // 4: 40 back-to-back commands with CQEs, wrapping all pointers
    for (int i = 0; i <= 40; i++) begin
      issue_valid = (i < 40);
      sq_bvalid = (i > 0);
      wb_bvalid = (i > 0);
      if (i < 40) exp_q.push_back(2'd0);
      cqe_valid = (i > 0);
      cqe_cid = 16'(100 + i);
      cqe_sqhd = 16'((12 + i) % 16);
      cqe_status = 0;
      tick();
    end
    issue_valid = 0; sq_bvalid = 0; wb_bvalid = 0; cqe_valid = 0;
    cyc(80);
    @(negedge clk);
    chk("t4_sqhead", cqdb_sqhead, 4);
    chk("t4_sq_data", sq_last, 4);
    chk("t4_cq_data", cq_last, 11);
    chk("t4_sq_wrapped", sq_wrapped, 1);
    chk("t4_cq_wrapped", cq_wrapped, 1);
    chk("t4_q_empty", exp_q.size(), 0);
    chk("t4_err_cid", err_cid, 7);

    // 6: reset while a doorbell is stalled on aw
    tick();
    hp_bready = 0;
    aw_stall = 1;
    issue_valid = 1; tick();
    issue_valid = 0; sq_bvalid = 1; wb_bvalid = 1; tick();
    sq_bvalid = 0; wb_bvalid = 0;
    k = 0;
    @(negedge clk);
    while (!nl.awvalid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("t6_aw_pending", nl.awvalid, 1);
    chk("t6_hp_pending", hp_bvalid, 1);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    chk("t6_awvalid", nl.awvalid, 0);
    chk("t6_wvalid", nl.wvalid, 0);
    chk("t6_hp_bvalid", hp_bvalid, 0);
    chk("t6_sqhead", cqdb_sqhead, 0);
    chk("t6_err_sticky", err_sticky, 0);
    chk("t6_err_cid", err_cid, 0);
    chk("t6_sq_bready", sq_bready, 0);
    chk("t6_cqe_ready", cqe_ready, 0);
    cyc(2);
    rstn = 1'b1;
    aw_stall = 0;
    hp_bready = 1;
    sq_last = 0;
    base = sq_cnt;
    tick();
    issue_valid = 1; exp_q.push_back(2'd0); tick();
    issue_valid = 0; sq_bvalid = 1; wb_bvalid = 1; tick();
    sq_bvalid = 0; wb_bvalid = 0;
    cyc(20);
    chk("t6_restart_writes", sq_cnt - base, 1);
    chk("t6_restart_data", sq_last, 1);
    chk("t6_q_empty", exp_q.size(), 0);
    chk("t6_err_clean", err_sticky, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
